johnson_counter_n: RTL

//  Parametrised shift-register counter. Generalises the fixed 4-bit Johnson counter in width
//  and direction, and adds a one-hot ring mode, synchronous phase load and phase decode.

---
 rtl/jcnt_pkg.sv | 53 +++++
 rtl/johnson_phase_decode.sv | 38 +++
 rtl/johnson_counter_n.sv | 106 ++++++++++
 3 files changed

// File: rtl/jcnt_pkg.sv
// Shared constants and helper functions for the Johnson / one-hot ring counter.
// Helpers work on a MAX_W-wide vector; callers zero-extend and pass the live width.
package jcnt_pkg;

    localparam int unsigned MODE_JOHNSON = 0;
    localparam int unsigned MODE_RING    = 1;
    localparam int unsigned MAX_W        = 32;

    // Counter state for phase index idx in a w-bit counter of the given mode.
    function automatic logic [MAX_W-1:0] encode_phase(
        input int unsigned idx,
        input int unsigned w,
        input int unsigned mode
    );
        logic [MAX_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                if (mode == MODE_RING)
                    v[i] = (i == idx);
                else if (idx <= w)
                    v[i] = (i < idx);
                else
                    v[i] = (i >= idx - w);
            end
        end
        return v;
    endfunction

    // Johnson: at most one adjacent-bit transition in q[w-1:0]; ring: exactly one bit set.
    function automatic logic is_legal(
        input logic [MAX_W-1:0] q,
        input int unsigned      w,
        input int unsigned      mode
    );
        int unsigned ones;
        int unsigned trans;
        ones  = 0;
        trans = 0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w && q[i])
                ones++;
        end
        for (int unsigned i = 0; i < MAX_W - 1; i++) begin
            if (i + 1 < w && q[i] != q[i+1])
                trans++;
        end
        if (mode == MODE_RING)
            return (ones == 1);
        return (trans <= 1);
    endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational decode of counter state to a binary phase index; illegal states decode to 0.
module johnson_phase_decode
    import jcnt_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MODE  = 0,
    parameter int unsigned PW    = 3
) (
    input  logic [WIDTH-1:0] i_q,
    output logic [PW-1:0]    o_phase_c,
    output logic             o_legal_c
);

    int unsigned w_ones;
    int unsigned w_idx;

    always_comb begin
        w_ones    = 0;
        w_idx     = 0;
        o_phase_c = '0;
        o_legal_c = is_legal(MAX_W'(i_q), WIDTH, MODE);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i_q[i]) begin
                w_ones++;
                w_idx = i;
            end
        end
        if (o_legal_c) begin
            if (MODE == MODE_RING)
                o_phase_c = PW'(w_idx);
            else if (!i_q[WIDTH-1])
                o_phase_c = PW'(w_ones);
            else
                o_phase_c = PW'(2 * WIDTH - w_ones);
        end
    end

endmodule

// File: rtl/johnson_counter_n.sv
// Parametrised Johnson / one-hot ring counter with phase load, phase decode and wrap strobe.
// Define JCNT_SELF_CORRECT_EN to enable illegal-state detection and recovery.
module johnson_counter_n
    import jcnt_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned MODE  = 0,
    localparam int unsigned PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [PW-1:0]    load_phase,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             load_err,
    output logic             illegal
);

    localparam int unsigned      NSTATE = (MODE == MODE_RING) ? WIDTH : 2 * WIDTH;
    localparam logic [WIDTH-1:0] RST_Q  = (MODE == MODE_RING) ? WIDTH'(1) : '0;

    generate
        if (WIDTH < 2 || WIDTH > MAX_W || MODE > 1) begin : g_bad_param
            $error("johnson_counter_n: illegal WIDTH/MODE parameters");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_load_err;
    logic             r_illegal;

    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_step;
    logic             w_wrap_nxt;
    logic             w_load_err_nxt;
    logic             w_illegal_nxt;
    logic [PW-1:0]    w_phase;
    logic             w_legal;

    johnson_phase_decode #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .PW    (PW)
    ) u_decode (
        .i_q       (r_q),
        .o_phase_c (w_phase),
        .o_legal_c (w_legal)
    );

    // Priority: load, then self-correction (when built in), then en step, else hold.
    always_comb begin
        w_q_nxt        = r_q;
        w_wrap_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
        w_illegal_nxt  = 1'b0;

        if (MODE == MODE_RING)
            w_step = dir ? {r_q[WIDTH-2:0], r_q[WIDTH-1]} : {r_q[0], r_q[WIDTH-1:1]};
        else
            w_step = dir ? {r_q[WIDTH-2:0], ~r_q[WIDTH-1]} : {~r_q[0], r_q[WIDTH-1:1]};

        if (load) begin
            if (32'(load_phase) < NSTATE)
                w_q_nxt = WIDTH'(encode_phase(32'(load_phase), WIDTH, MODE));
            else
                w_load_err_nxt = 1'b1;
        end
`ifdef JCNT_SELF_CORRECT_EN
        else if (!w_legal) begin
            w_q_nxt       = RST_Q;
            w_illegal_nxt = 1'b1;
        end
`endif
        else if (en) begin
            w_q_nxt    = w_step;
            w_wrap_nxt = dir ? (w_phase == PW'(NSTATE - 1))
                             : (w_phase == '0 && w_legal);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q        <= RST_Q;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_q        <= w_q_nxt;
            r_wrap     <= w_wrap_nxt;
            r_load_err <= w_load_err_nxt;
            r_illegal  <= w_illegal_nxt;
        end
    end

    assign q        = r_q;
    assign phase    = w_phase;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;
    assign illegal  = r_illegal;

endmodule
